// File: rtl/crt_ff_rd_ctl_if.sv
// Read port of the 32-entry ping-pong CRT FIFO RAM.
// The controller drives address and strobe. The RAM returns data one cycle later.
interface crt_ff_rd_ctl_if #(parameter int DW = 32);
  logic [4:0]    ff_rd_addr;
  logic          ff_rd_en;
  logic [DW-1:0] ff_rd_data;

  modport master (output ff_rd_addr, output ff_rd_en, input ff_rd_data);
  modport slave  (input ff_rd_addr, input ff_rd_en, output ff_rd_data);
endinterface

// File: rtl/crt_ff_rd_ctl.sv
// CRT-side read controller for the 32-entry ping-pong FIFO.
// Half A holds entries 0-15 and half B holds entries 16-31.
// The block tracks half-full handoffs from the mem_clk side, issues RAM reads
// on qualifying dot clocks and returns registered words to the serializer.
// It also produces the position pulses that the write side consumes.
module crt_ff_rd_ctl #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                t_crt_clk,
  input  logic                hreset_n,
  input  logic                c_dclk_en,
  input  logic                c_crt_line_end,
  input  logic                c_vdisp_end,
  input  logic                c_crt_ff_read,
  input  logic                a_fill_tgl,
  input  logic                b_fill_tgl,
  crt_ff_rd_ctl_if.master     ram,
  output logic [DW-1:0]       crt_data,
  output logic                crt_data_vld,
  output logic                crt_frd1,
  output logic                crt_frd15,
  output logic                crt_frd16,
  output logic                crt_frd17,
  output logic                crt_frd31,
  output logic                a_ready,
  output logic                b_ready,
  output logic                underrun,
  output logic                fill_err
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B} state_t;

  state_t                 state, state_nxt;
  logic [4:0]             rd_addr, rd_addr_nxt;
  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic                   a_hist, b_hist;
  logic                   fill_a, fill_b;
  logic                   take, restart, active_ready, rd_en;
  logic                   clr_a, clr_b, under_set;
  logic                   rd_pend;

  // Toggle synchronizers plus edge history. These run every clock, independent of the dot enable.
  // NOTE: sequential state uses non-blocking assignments only. All flops then sample pre-edge values.
  always_ff @(posedge t_crt_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      a_sync <= '0;
      b_sync <= '0;
      a_hist <= 1'b0;
      b_hist <= 1'b0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a_fill_tgl};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b_fill_tgl};
      a_hist <= a_sync[SYNC_STAGES-1];
      b_hist <= b_sync[SYNC_STAGES-1];
    end
  end

  assign fill_a  = a_sync[SYNC_STAGES-1] ^ a_hist;
  assign fill_b  = b_sync[SYNC_STAGES-1] ^ b_hist;
  assign take    = c_dclk_en & c_crt_ff_read;
  assign restart = c_crt_line_end | c_vdisp_end;

  // Readiness of the half that the FSM is currently draining. In IDLE, this is half A.
  assign active_ready = (state == RD_B) ? b_ready : a_ready;
  assign rd_en        = take & active_ready & ~restart & ((state != IDLE) | a_ready);

  // Next-state and address logic. Restart wins over reads, and reads win over underrun detection.
  // NOTE: every signal gets a default first. No path can then leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    clr_a       = 1'b0;
    clr_b       = 1'b0;
    under_set   = 1'b0;
    if (restart) begin
      state_nxt   = IDLE;
      rd_addr_nxt = 5'd0;
    end else if (rd_en) begin
      rd_addr_nxt = rd_addr + 5'd1;          // 31 wraps to 0 naturally
      if (rd_addr == 5'd15) begin
        state_nxt = RD_B;
        clr_a     = 1'b1;
      end else if (rd_addr == 5'd31) begin
        state_nxt = RD_A;
        clr_b     = 1'b1;
      end else if (state == IDLE) begin
        state_nxt = RD_A;
      end
    end else if (take) begin
      under_set = 1'b1;
    end
  end

  // FSM state register and read address register.
  always_ff @(posedge t_crt_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state   <= IDLE;
      rd_addr <= 5'd0;
    end else begin
      state   <= state_nxt;
      rd_addr <= rd_addr_nxt;
    end
  end

  // Ready flags and error flags. A clear of a half is applied before a fill of the same half.
  always_ff @(posedge t_crt_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      a_ready  <= 1'b0;
      b_ready  <= 1'b0;
      underrun <= 1'b0;
      fill_err <= 1'b0;
    end else begin
      a_ready  <= ~restart & ((a_ready & ~clr_a) | fill_a);
      b_ready  <= ~restart & ((b_ready & ~clr_b) | fill_b);
      underrun <= ~restart & (underrun | under_set);
      fill_err <= fill_err | (~restart & ((fill_a & a_ready & ~clr_a) |
                                          (fill_b & b_ready & ~clr_b)));
    end
  end

  // Return path. RAM data is valid in the cycle after the strobe and is captured at the end of that cycle.
  // A restart in that cycle drops the word in flight.
  // NOTE: the data register is reset as well. The serializer must never see X after reset.
  always_ff @(posedge t_crt_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      rd_pend      <= 1'b0;
      crt_data_vld <= 1'b0;
      crt_data     <= '0;
    end else begin
      rd_pend      <= rd_en;
      crt_data_vld <= rd_pend & ~restart;
      if (rd_pend && !restart) crt_data <= ram.ff_rd_data;
    end
  end

  assign ram.ff_rd_addr = rd_addr;
  assign ram.ff_rd_en   = rd_en;

  // Position pulses. The address advances after every read, so no pulse can repeat on back-to-back cycles.
  assign crt_frd1  = rd_en & (rd_addr == 5'd1);
  assign crt_frd15 = rd_en & (rd_addr == 5'd15);
  assign crt_frd16 = rd_en & (rd_addr == 5'd16);
  assign crt_frd17 = rd_en & (rd_addr == 5'd17);
  assign crt_frd31 = rd_en & (rd_addr == 5'd31);

endmodule

// File: tb/tb_crt_ff_rd_ctl.sv
// Self-checking bench for crt_ff_rd_ctl.
// A behavioural FIFO RAM and a read scoreboard check every issued read, every returned word and every position pulse.
// A table of fill/take phases and hand-written corner sequences drive the stimulus.
module tb_crt_ff_rd_ctl;
  localparam int DW   = 32;
  localparam int SYNC = 2;

  logic          t_crt_clk = 1'b0;
  logic          hreset_n  = 1'b1;
  logic          c_dclk_en = 1'b0, c_crt_line_end = 1'b0, c_vdisp_end = 1'b0;
  logic          c_crt_ff_read = 1'b0, a_fill_tgl = 1'b0, b_fill_tgl = 1'b0;
  logic [DW-1:0] crt_data;
  logic          crt_data_vld, crt_frd1, crt_frd15, crt_frd16, crt_frd17, crt_frd31;
  logic          a_ready, b_ready, underrun, fill_err;

  crt_ff_rd_ctl_if #(.DW(DW)) ram_if ();

  crt_ff_rd_ctl #(.DW(DW), .SYNC_STAGES(SYNC)) dut (
    .t_crt_clk      (t_crt_clk),
    .hreset_n       (hreset_n),
    .c_dclk_en      (c_dclk_en),
    .c_crt_line_end (c_crt_line_end),
    .c_vdisp_end    (c_vdisp_end),
    .c_crt_ff_read  (c_crt_ff_read),
    .a_fill_tgl     (a_fill_tgl),
    .b_fill_tgl     (b_fill_tgl),
    .ram            (ram_if.master),
    .crt_data       (crt_data),
    .crt_data_vld   (crt_data_vld),
    .crt_frd1       (crt_frd1),
    .crt_frd15      (crt_frd15),
    .crt_frd16      (crt_frd16),
    .crt_frd17      (crt_frd17),
    .crt_frd31      (crt_frd31),
    .a_ready        (a_ready),
    .b_ready        (b_ready),
    .underrun       (underrun),
    .fill_err       (fill_err)
  );

  always #5 t_crt_clk = ~t_crt_clk;

  // FIFO RAM model with one-cycle read latency.
  logic [DW-1:0] ram [32];
  always @(posedge t_crt_clk) if (ram_if.ff_rd_en) ram_if.ff_rd_data <= ram[ram_if.ff_rd_addr];

  int            n_checks = 0, n_errors = 0, rd_cnt = 0, start;
  logic [DW-1:0] sb [$];
  logic [4:0]    exp_rd_addr = 5'd0;
  bit            mon_on = 1'b0;

  typedef struct {
    string      name;
    bit         fa, fb;
    int         n, p, reads;
    logic [4:0] addr;
    bit         ar, br, un, fe;
  } row_t;
  row_t rows [5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {16'h0, ram_if.ff_rd_addr, ram_if.ff_rd_en, crt_data, crt_data_vld,
            crt_frd1, crt_frd15, crt_frd16, crt_frd17, crt_frd31,
            a_ready, b_ready, underrun, fill_err};
  endfunction

  // Sampled mid-cycle. This routine pops returned words, checks the pulses and pushes new reads.
  task automatic monitor();
    logic [4:0]    act_frd, exp_frd;
    logic [DW-1:0] e;
    if (!mon_on) return;
    act_frd = {crt_frd31, crt_frd17, crt_frd16, crt_frd15, crt_frd1};
    exp_frd = ram_if.ff_rd_en ? {exp_rd_addr == 5'd31, exp_rd_addr == 5'd17, exp_rd_addr == 5'd16,
                                 exp_rd_addr == 5'd15, exp_rd_addr == 5'd1} : 5'd0;
    if (crt_data_vld) begin
      if (sb.size() == 0) check("crt_data_vld_unexpected", crt_data_vld, 1'b0);
      else begin
        e = sb.pop_front();
        check("crt_data", crt_data, e);
      end
    end
    if (ram_if.ff_rd_en || act_frd != 5'd0) check("frd_pulses", act_frd, exp_frd);
    if (ram_if.ff_rd_en) begin
      check("rd_addr", ram_if.ff_rd_addr, exp_rd_addr);
      check("rd_dclk_align", c_dclk_en, 1'b1);
      sb.push_back(ram[exp_rd_addr]);
      exp_rd_addr = exp_rd_addr + 5'd1;
      rd_cnt++;
    end
  endtask

  // One clock. The bench monitors at the falling edge and returns 1 time unit after the next rising edge.
  task automatic step();
    @(negedge t_crt_clk);
    monitor();
    @(posedge t_crt_clk);
    #1;
  endtask

  task automatic flip(input bit fa, input bit fb);
    if (fa) a_fill_tgl = ~a_fill_tgl;
    if (fb) b_fill_tgl = ~b_fill_tgl;
    repeat (SYNC + 2) step();
  endtask

  // n takes. The dot enable is high on one cycle in p, and the read request is held high throughout.
  task automatic takes(input int n, input int p);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++) begin
        c_crt_ff_read = 1'b1;
        c_dclk_en     = (j == p - 1);
        step();
      end
    c_crt_ff_read = 1'b0;
    c_dclk_en     = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 32'hC0DE_0000 + i * 32'h0001_0101;
    rows[0] = '{"half_a",      1'b0, 1'b0, 16, 1, 16, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0};
    rows[1] = '{"half_b_slow", 1'b0, 1'b1, 16, 4, 16, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    rows[2] = '{"both_slow",   1'b1, 1'b1, 32, 4, 32, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    rows[3] = '{"a_only_20",   1'b1, 1'b0, 20, 1, 16, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0};
    rows[4] = '{"b_resume",    1'b0, 1'b1, 16, 1, 16, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0};

    #2 hreset_n = 1'b0;
    #1 check("reset_outputs", out_vec(), 64'h0);
    @(posedge t_crt_clk);
    @(posedge t_crt_clk);
    #1 hreset_n = 1'b1;
    mon_on = 1'b1;

    // a_ready must rise SYNC+1 edges after the toggle flips.
    a_fill_tgl = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      step();
      check($sformatf("a_ready_latency_%0d", k), a_ready, k == SYNC + 1);
    end
    step();

    foreach (rows[r]) begin
      if (rows[r].fa || rows[r].fb) flip(rows[r].fa, rows[r].fb);
      start = rd_cnt;
      takes(rows[r].n, rows[r].p);
      check({rows[r].name, "_reads"}, rd_cnt - start, rows[r].reads);
      check({rows[r].name, "_addr"}, ram_if.ff_rd_addr, rows[r].addr);
      check({rows[r].name, "_ready"}, {a_ready, b_ready}, {rows[r].ar, rows[r].br});
      check({rows[r].name, "_underrun"}, underrun, rows[r].un);
      check({rows[r].name, "_fill_err"}, fill_err, rows[r].fe);
    end

    // Line end at address 7. The read in flight from address 6 must be dropped.
    flip(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      c_crt_ff_read  = 1'b1;
      c_dclk_en      = 1'b1;
      c_crt_line_end = (i == 7);
      if (i == 7) begin
        #1;
        check("restart_no_read", ram_if.ff_rd_en, 1'b0);
        check("restart_at_addr7", ram_if.ff_rd_addr, 5'd7);
      end
      step();
    end
    c_crt_ff_read  = 1'b0;
    c_dclk_en      = 1'b0;
    c_crt_line_end = 1'b0;
    sb.delete();
    exp_rd_addr = 5'd0;
    check("line_end_state", {ram_if.ff_rd_addr, a_ready, b_ready, underrun, crt_data_vld}, 9'd0);
    check("line_end_data_hold", crt_data, ram[5]);
    repeat (2) step();

    // A second fill while the half is still ready is an error. The ready flag stays set.
    flip(1'b1, 1'b0);
    check("fill_once", {a_ready, fill_err}, 2'b10);
    flip(1'b1, 1'b0);
    check("fill_twice", {a_ready, fill_err}, 2'b11);
    c_vdisp_end = 1'b1;
    step();
    c_vdisp_end = 1'b0;
    check("vdisp_clears", {a_ready, fill_err}, 2'b01);

    // A fill_b pulse that lands in the same cycle as vdisp_end must be discarded.
    b_fill_tgl = ~b_fill_tgl;
    step();
    step();
    c_vdisp_end = 1'b1;
    step();
    c_vdisp_end = 1'b0;
    repeat (3) step();
    check("fill_vs_restart", {b_ready, fill_err}, 2'b01);

    // Asynchronous reset in the middle of half B.
    flip(1'b1, 1'b1);
    takes(20, 1);
    check("pre_reset_addr", ram_if.ff_rd_addr, 5'd20);
    c_dclk_en     = 1'b1;
    c_crt_ff_read = 1'b1;
    #1;
    hreset_n   = 1'b0;
    a_fill_tgl = 1'b0;
    b_fill_tgl = 1'b0;
    mon_on     = 1'b0;
    #1 check("async_reset_outputs", out_vec(), 64'h0);
    repeat (3) step();
    hreset_n = 1'b1;
    sb.delete();
    exp_rd_addr = 5'd0;
    mon_on = 1'b1;
    start  = rd_cnt;
    repeat (10) step();
    check("post_reset_no_reads", rd_cnt - start, 0);
    check("post_reset_state", {ram_if.ff_rd_addr, a_ready, underrun}, {5'd0, 1'b0, 1'b1});
    c_dclk_en     = 1'b0;
    c_crt_ff_read = 1'b0;
    flip(1'b1, 1'b0);
    start = rd_cnt;
    takes(1, 1);
    check("post_reset_resume", {rd_cnt - start, 27'd0, ram_if.ff_rd_addr}, {32'd1, 27'd0, 5'd1});

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
